wiz_bus_ctrl: RTL

Two-requester arbiter and bus-timing sequencer for the W5300 16-bit host bus (WIZ_A/WIZ_D/WIZ_CS_N/WIZ_RD_N/WIZ_WR_N).
- Lets a CPU-side port (req0) and a DMA/packet-mover port (req1) share the chip.
- Generates the chip-select and strobe windows with programmable setup, strobe, hold and recovery cycles.
- Tristating of WIZ_D is done at the top level from WIZ_D_OUT/WIZ_D_OE.

---
 rtl/wiz_bus_ctrl_if.sv | 43 ++++
 rtl/wiz_bus_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wiz_bus_ctrl_if.sv
// wiz_bus_ctrl_if: requester handshake plus W5300 host-bus signals.
//   slave  : the controller side (takes requests, drives the chip bus)
//   master : the requester/chip side (drives requests and chip inputs)
// Port 0 / port 1 request groups: REQn, WRn, ADDRn, WDATAn in; ACKn out.
// Shared: RDATA, BUSY, IRQ out. Chip: WIZ_A, WIZ_D_OUT, WIZ_D_OE,
// WIZ_CS_N, WIZ_RD_N, WIZ_WR_N out; WIZ_D_IN, WIZ_INT_N in.
interface wiz_bus_ctrl_if;
  logic        REQ0;
  logic        WR0;
  logic [9:0]  ADDR0;
  logic [15:0] WDATA0;
  logic        ACK0;
  logic        REQ1;
  logic        WR1;
  logic [9:0]  ADDR1;
  logic [15:0] WDATA1;
  logic        ACK1;
  logic [15:0] RDATA;
  logic        BUSY;
  logic [9:0]  WIZ_A;
  logic [15:0] WIZ_D_OUT;
  logic        WIZ_D_OE;
  logic [15:0] WIZ_D_IN;
  logic        WIZ_CS_N;
  logic        WIZ_RD_N;
  logic        WIZ_WR_N;
  logic        WIZ_INT_N;
  logic        IRQ;

  modport slave (
    input  REQ0, WR0, ADDR0, WDATA0, REQ1, WR1, ADDR1, WDATA1,
           WIZ_D_IN, WIZ_INT_N,
    output ACK0, ACK1, RDATA, BUSY, WIZ_A, WIZ_D_OUT, WIZ_D_OE,
           WIZ_CS_N, WIZ_RD_N, WIZ_WR_N, IRQ
  );

  modport master (
    output REQ0, WR0, ADDR0, WDATA0, REQ1, WR1, ADDR1, WDATA1,
           WIZ_D_IN, WIZ_INT_N,
    input  ACK0, ACK1, RDATA, BUSY, WIZ_A, WIZ_D_OUT, WIZ_D_OE,
           WIZ_CS_N, WIZ_RD_N, WIZ_WR_N, IRQ
  );
endinterface

// File: rtl/wiz_bus_ctrl.sv
// wiz_bus_ctrl: two-requester round-robin arbiter and W5300 host-bus
// timing sequencer. One access at a time walks IDLE -> SETUP -> STROBE ->
// HOLD -> RECOVER with programmable phase lengths; all outputs registered.
// Ports:
//   CLK  : system clock
//   RST  : synchronous reset, active-high
//   bus  : wiz_bus_ctrl_if.slave (requests, ACKs, RDATA, BUSY, IRQ, chip bus)
// Optional macro WIZ_INT_SYNC_EN: when defined, WIZ_INT_N is synchronized
// through two flops and IRQ is its registered inverse; otherwise IRQ is 0.
//
// state   | meaning
// IDLE    | arbitrate; on grant latch request and enter SETUP
// SETUP   | CS_N low, address (and write data) driven, strobes high
// STROBE  | RD_N or WR_N low; read data captured on the last edge
// HOLD    | strobe high, CS_N still low, address/data still driven
// RECOVER | CS_N high, bus released; ACK pulses in the first cycle
module wiz_bus_ctrl #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  wiz_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_grant_q;
  logic        gnt_q;
  logic        wr_q;
  logic        ack0_q, ack1_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic [9:0]  addr_q;
  logic [15:0] dout_q;
  logic        doe_q;
  logic        cs_n_q, rd_n_q, wr_n_q;

  // Port 1 wins if it is alone, or if both request and port 0 went last.
  logic        sel1;
  logic        sel_wr;
  logic [9:0]  sel_addr;
  logic [15:0] sel_wdata;

  always_comb begin
    sel1      = bus.REQ1 && (!bus.REQ0 || !last_grant_q);
    sel_wr    = sel1 ? bus.WR1    : bus.WR0;
    sel_addr  = sel1 ? bus.ADDR1  : bus.ADDR0;
    sel_wdata = sel1 ? bus.WDATA1 : bus.WDATA0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= 16'h0000;
      busy_q       <= 1'b0;
      addr_q       <= 10'h000;
      dout_q       <= 16'h0000;
      doe_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            gnt_q        <= sel1;
            last_grant_q <= sel1;
            wr_q         <= sel_wr;
            addr_q       <= sel_addr;
            if (sel_wr) begin
              dout_q <= sel_wdata;
              doe_q  <= 1'b1;
            end
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= 4'(SETUP_CYC - 1);
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            if (wr_q) wr_n_q <= 1'b0;
            else      rd_n_q <= 1'b0;
            cnt_q   <= 4'(STROBE_CYC - 1);
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            if (!wr_q) rdata_q <= bus.WIZ_D_IN;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            cnt_q   <= 4'(HOLD_CYC - 1);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            cs_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            cnt_q   <= 4'(RECOVER_CYC - 1);
            state_q <= RECOVER;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          if (cnt_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WIZ_INT_SYNC_EN
  logic int_s1_q, int_s2_q, irq_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      int_s1_q <= 1'b1;
      int_s2_q <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      int_s1_q <= bus.WIZ_INT_N;
      int_s2_q <= int_s1_q;
      irq_q    <= ~int_s2_q;
    end
  end

  assign bus.IRQ = irq_q;
`else
  assign bus.IRQ = 1'b0;
`endif

  assign bus.ACK0      = ack0_q;
  assign bus.ACK1      = ack1_q;
  assign bus.RDATA     = rdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.WIZ_A     = addr_q;
  assign bus.WIZ_D_OUT = dout_q;
  assign bus.WIZ_D_OE  = doe_q;
  assign bus.WIZ_CS_N  = cs_n_q;
  assign bus.WIZ_RD_N  = rd_n_q;
  assign bus.WIZ_WR_N  = wr_n_q;

endmodule
